// File: rtl/frame_painter.sv
// Raster-scan painter: issues coordinates to fixed-latency layers, composites
// their responses by priority and streams RGB565 pixels through a small FIFO.
module frame_painter #(
  parameter int          SCREEN_W   = 320,
  parameter int          SCREEN_H   = 480,
  parameter int          LATENCY    = 4,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] BG_COLOR   = 16'h4E19
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               frame_start,
  output logic               busy,
  output logic               frame_done,
  output logic signed [15:0] paint_x,
  output logic signed [15:0] paint_y,
  input  logic               en0,
  input  logic [15:0]        color0,
  input  logic               en1,
  input  logic [15:0]        color1,
  input  logic               en2,
  input  logic [15:0]        color2,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic [15:0]        pix_data,
  output logic               pix_last
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int IW = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

  state_t             state, state_next;
  logic [15:0]        cnt_x, cnt_y, cnt_x_next, cnt_y_next;
  logic [LATENCY-1:0] trk_valid, trk_last;
  logic [IW-1:0]      in_flight;
  logic [CW-1:0]      fifo_count;
  logic [PW-1:0]      wr_ptr, rd_ptr;
  logic [15:0]        mem_data [FIFO_DEPTH];
  logic               mem_last [FIFO_DEPTH];
  logic               credit, issue, issue_last, at_end_x, at_end_y;
  logic               push, pop, ret_last, done_next;
  logic [15:0]        push_data;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (int'(p) == FIFO_DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    in_flight = '0;
    for (int i = 0; i < LATENCY; i++)
      in_flight = in_flight + IW'(trk_valid[i]);
  end

  // Issue only when every in-flight response is guaranteed a FIFO slot
  assign credit     = (int'(in_flight) + int'(fifo_count)) < FIFO_DEPTH;
  assign at_end_x   = (cnt_x == 16'(SCREEN_W - 1));
  assign at_end_y   = (cnt_y == 16'(SCREEN_H - 1));
  assign issue      = (state == SCAN) && credit;
  assign issue_last = issue && at_end_x && at_end_y;
  assign push       = trk_valid[LATENCY-1];
  assign ret_last   = trk_last[LATENCY-1];
  assign pop        = pix_valid && pix_ready;

  always_comb begin
    if (en0)      push_data = color0;
    else if (en1) push_data = color1;
    else if (en2) push_data = color2;
    else          push_data = BG_COLOR;
  end

  always_comb begin
    state_next = state;
    cnt_x_next = cnt_x;
    cnt_y_next = cnt_y;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (frame_start && !frame_done) begin
          state_next = SCAN;
          cnt_x_next = '0;
          cnt_y_next = '0;
        end
      end
      SCAN: begin
        if (issue) begin
          if (at_end_x) begin
            if (at_end_y) begin
              state_next = DRAIN;
            end else begin
              cnt_x_next = '0;
              cnt_y_next = cnt_y + 16'd1;
            end
          end else begin
            cnt_x_next = cnt_x + 16'd1;
          end
        end
      end
      DRAIN: begin
        if (pop && pix_last) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      cnt_x      <= '0;
      cnt_y      <= '0;
      frame_done <= 1'b0;
      trk_valid  <= '0;
      trk_last   <= '0;
    end else begin
      state      <= state_next;
      cnt_x      <= cnt_x_next;
      cnt_y      <= cnt_y_next;
      frame_done <= done_next;
      trk_valid  <= (trk_valid << 1) | LATENCY'(issue);
      trk_last   <= (trk_last << 1) | LATENCY'(issue_last);
    end
  end

  // Storage is reset so the head reads zero before the first pixel arrives
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_data[i] <= '0;
        mem_last[i] <= 1'b0;
      end
    end else begin
      if (push) begin
        mem_data[wr_ptr] <= push_data;
        mem_last[wr_ptr] <= ret_last;
        wr_ptr           <= ptr_inc(wr_ptr);
      end
      if (pop)
        rd_ptr <= ptr_inc(rd_ptr);
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
    end
  end

  assign busy      = (state != IDLE);
  assign paint_x   = cnt_x;
  assign paint_y   = cnt_y;
  assign pix_valid = (fifo_count != '0);
  assign pix_data  = mem_data[rd_ptr];
  assign pix_last  = pix_valid && mem_last[rd_ptr];

endmodule

// File: tb/tb_frame_painter.sv
// Randomized scoreboard bench for frame_painter on a 4x3 screen with a
// latency-accurate layer model and a priority-compositing reference.
module tb_frame_painter;

  localparam int          W     = 4;
  localparam int          H     = 3;
  localparam int          LAT   = 4;
  localparam int          DEPTH = 8;
  localparam logic [15:0] BG    = 16'h4E19;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic frame_start = 1'b0;
  logic pix_ready = 1'b0;
  logic en0 = 1'b0, en1 = 1'b0, en2 = 1'b0;
  logic [15:0] color0 = '0, color1 = '0, color2 = '0;
  logic busy, frame_done, pix_valid, pix_last;
  logic signed [15:0] paint_x, paint_y;
  logic [15:0] pix_data;

  typedef struct packed {logic [15:0] data; logic last;} pix_t;

  pix_t        exp_q[$];
  logic        lay_en  [3][H][W];
  logic [15:0] lay_col [3][H][W];
  int          hx [LAT+1];
  int          hy [LAT+1];
  int          ready_mode = 1;
  int          compared = 0;
  int          mismatched = 0;
  int          accepted = 0;
  int          done_cnt = 0;
  logic        done_due = 1'b0;

  frame_painter #(
    .SCREEN_W(W), .SCREEN_H(H), .LATENCY(LAT), .FIFO_DEPTH(DEPTH), .BG_COLOR(BG)
  ) dut (
    .clk(clk), .rstn(rstn), .frame_start(frame_start), .busy(busy),
    .frame_done(frame_done), .paint_x(paint_x), .paint_y(paint_y),
    .en0(en0), .color0(color0), .en1(en1), .color1(color1),
    .en2(en2), .color2(color2), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_data(pix_data), .pix_last(pix_last)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Layers answer whatever coordinate was on the bus LAT cycles earlier
  always @(negedge clk) begin
    for (int i = LAT; i > 0; i--) begin
      hx[i] = hx[i-1];
      hy[i] = hy[i-1];
    end
    hx[0] = int'($unsigned(paint_x));
    hy[0] = int'($unsigned(paint_y));
    if (hx[LAT] < W && hy[LAT] < H) begin
      en0 = lay_en[0][hy[LAT]][hx[LAT]]; color0 = lay_col[0][hy[LAT]][hx[LAT]];
      en1 = lay_en[1][hy[LAT]][hx[LAT]]; color1 = lay_col[1][hy[LAT]][hx[LAT]];
      en2 = lay_en[2][hy[LAT]][hx[LAT]]; color2 = lay_col[2][hy[LAT]][hx[LAT]];
    end else begin
      en0 = 1'b0; en1 = 1'b0; en2 = 1'b0;
    end
  end

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       pix_ready = 1'b0;
      1:       pix_ready = 1'b1;
      default: pix_ready = ($urandom_range(0, 1) == 1);
    endcase
  end

  // Monitor: pops the scoreboard on every accepted pixel
  always @(negedge clk) begin
    if (!rstn) begin
      done_due = 1'b0;
    end else begin
      if (done_due) begin
        check_output("done_after_last", frame_done, 1);
        check_output("busy_low_on_done", busy, 0);
        done_due = 1'b0;
      end
      if (frame_done) done_cnt++;
      if (dut.push) check_output("fifo_no_overflow", int'(dut.fifo_count) < DEPTH, 1);
      if (pix_valid && pix_ready) begin
        accepted++;
        if (exp_q.size() == 0) begin
          check_output("unexpected_pixel", 1, 0);
        end else begin
          pix_t e;
          e = exp_q.pop_front();
          check_output("pix_data", pix_data, e.data);
          check_output("pix_last", pix_last, e.last);
          if (e.last) done_due = 1'b1;
        end
      end
    end
  end

  task automatic set_layers(input int mode);
    for (int l = 0; l < 3; l++)
      for (int y = 0; y < H; y++)
        for (int x = 0; x < W; x++) begin
          lay_en[l][y][x]  = (mode == 2) ? ($urandom_range(0, 2) == 0) : 1'b0;
          lay_col[l][y][x] = 16'($urandom);
        end
    if (mode == 1) begin
      lay_en[0][1][2] = 1'b1; lay_col[0][1][2] = 16'hF800;
      lay_en[1][1][2] = 1'b1; lay_col[1][1][2] = 16'h07E0;
      lay_en[1][1][3] = 1'b1; lay_col[1][1][3] = 16'h07E0;
    end
  endtask

  task automatic load_expected();
    pix_t p;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        p.data = BG;
        for (int l = 2; l >= 0; l--)
          if (lay_en[l][y][x]) p.data = lay_col[l][y][x];
        p.last = (x == W - 1) && (y == H - 1);
        exp_q.push_back(p);
      end
  endtask

  task automatic apply_stimulus(input bit expect_frame);
    @(negedge clk);
    frame_start = 1'b1;
    if (expect_frame) load_expected();
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic wait_frame(input string name, input int budget);
    int start_cnt;
    int n;
    start_cnt = done_cnt;
    n = 0;
    while (done_cnt == start_cnt && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    check_output({name, "_done_seen"}, done_cnt != start_cnt, 1);
    repeat (6) @(negedge clk);
    #1;
    check_output({name, "_done_once"}, done_cnt - start_cnt, 1);
    check_output({name, "_queue_empty"}, exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string name);
    check_output({name, "_paint_x"}, paint_x, 0);
    check_output({name, "_paint_y"}, paint_y, 0);
    check_output({name, "_busy"}, busy, 0);
    check_output({name, "_frame_done"}, frame_done, 0);
    check_output({name, "_pix_valid"}, pix_valid, 0);
    check_output({name, "_pix_last"}, pix_last, 0);
    check_output({name, "_pix_data"}, pix_data, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    int base;
    int start_cnt;
    logic [15:0] held;
    set_layers(0);
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // Plain background frame, full-rate output and first-pixel latency
    apply_stimulus(1);
    check_output("start_x", paint_x, 0);
    check_output("start_y", paint_y, 0);
    lat = 0;
    while (!pix_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check_output("first_pixel_latency", lat, LAT + 1);
    check_output("busy_during_frame", busy, 1);
    wait_frame("bg_frame", 200);

    $display("[TB] layer priority frame");
    set_layers(1);
    apply_stimulus(1);
    wait_frame("priority_frame", 200);

    $display("[TB] backpressure from start");
    ready_mode = 0;
    repeat (2) @(negedge clk);
    set_layers(2);
    apply_stimulus(1);
    repeat (30) @(negedge clk);
    check_output("stall_x", paint_x, 0);
    check_output("stall_y", paint_y, 2);
    check_output("stall_valid", pix_valid, 1);
    check_output("stall_head", pix_data, exp_q[0].data);
    held = pix_data;
    repeat (5) @(negedge clk);
    check_output("stall_data_stable", pix_data, held);
    check_output("stall_x_frozen", paint_x, 0);
    check_output("stall_y_frozen", paint_y, 2);
    ready_mode = 1;
    wait_frame("stall_frame", 200);

    $display("[TB] random ready frames");
    ready_mode = 2;
    for (int f = 0; f < 3; f++) begin
      set_layers(2);
      apply_stimulus(1);
      wait_frame("random_frame", 400);
    end

    $display("[TB] ignored frame_start pulses");
    ready_mode = 1;
    repeat (2) @(negedge clk);
    set_layers(2);
    start_cnt = done_cnt;
    base = accepted;
    apply_stimulus(1);
    repeat (4) @(negedge clk);
    apply_stimulus(0);
    check_output("busy_after_mid_start", busy, 1);
    lat = 0;
    while (!frame_done && lat < 100) begin
      @(negedge clk);
      check_output("busy_until_done", busy, !frame_done);
      lat++;
    end
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_output("ignored_done_start_busy", busy, 0);
    check_output("ignored_done_start_valid", pix_valid, 0);
    check_output("one_done_for_frame", done_cnt - start_cnt, 1);
    check_output("ignored_pixels", accepted - base, W * H);
    apply_stimulus(1);
    check_output("restart_x", paint_x, 0);
    check_output("restart_y", paint_y, 0);
    wait_frame("restart_frame", 200);

    $display("[TB] reset mid-frame");
    set_layers(2);
    start_cnt = done_cnt;
    base = accepted;
    apply_stimulus(1);
    lat = 0;
    while (accepted - base < 5 && lat < 100) begin
      @(negedge clk); #1;
      lat++;
    end
    check_output("five_accepted", accepted - base, 5);
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    exp_q.delete();
    repeat (4) @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    check_output("no_done_on_reset", done_cnt - start_cnt, 0);
    apply_stimulus(1);
    wait_frame("post_reset_frame", 200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
